// File: rtl/scaler_interp_hor.sv
// Horizontal linear interpolator: two-tap RGB window blended by a 7-bit phase weight.
// Two-stage pipeline (products, then rounded sums) with output-pixel counter and end-of-line pulse.
module scaler_interp_hor #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 11
) (
    input  logic          iCLK,
    input  logic          iRSTN,
    input  logic          iEN,
    input  logic [6:0]    iWEIGHT,
    input  logic          iPIX_EN,
    input  logic [DW-1:0] iR,
    input  logic [DW-1:0] iG,
    input  logic [DW-1:0] iB,
    output logic          oDVAL,
    output logic [DW-1:0] oR,
    output logic [DW-1:0] oG,
    output logic [DW-1:0] oB,
    output logic          oEOL,
    output logic [CW-1:0] oPIX_CNT
);

    localparam int unsigned PW = DW + 7;
    localparam int unsigned SW = DW + 8;

    // Channel index: 2 = R, 1 = G, 0 = B.
    logic [2:0][DW-1:0] pix;
    logic [2:0][DW-1:0] p0_q, p0_d, p1_q, p1_d;
    logic               primed_q, primed_d;

    logic [7:0]         wc;
    logic [2:0][PW-1:0] prod0_q, prod0_d, prod1_q, prod1_d;
    logic               s1_vld_q, s1_vld_d;

    logic [2:0][SW-1:0] sum;
    logic [2:0][DW-1:0] out_q, out_d;
    logic               dval_q, dval_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               unused_sum;

    assign pix = {iR, iG, iB};

    always_comb begin
        primed_d = primed_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        if (iPIX_EN) begin
            // First strobe of a line fills both taps to replicate the left edge.
            if (!primed_q) begin
                p0_d = pix;
                p1_d = pix;
            end else begin
                p0_d = p1_q;
                p1_d = pix;
            end
            primed_d = 1'b1;
        end else if (!iEN) begin
            primed_d = 1'b0;
        end
    end

    always_comb begin
        wc       = 8'd128 - {1'b0, iWEIGHT};
        s1_vld_d = iEN;
        dval_d   = s1_vld_q;
        prod0_d  = '0;
        prod1_d  = '0;
        sum      = '0;
        out_d    = '0;
        for (int c = 0; c < 3; c++) begin
            prod0_d[c] = PW'(p0_q[c]) * PW'(wc);
            prod1_d[c] = PW'(p1_q[c]) * PW'(iWEIGHT);
            sum[c]     = SW'(prod0_q[c]) + SW'(prod1_q[c]) + SW'(64);
            // Blend never exceeds the larger tap, so the top sum bit is always zero.
            out_d[c]   = sum[c][DW+6:7];
        end
        cnt_d = dval_q ? cnt_q + CW'(1) : '0;
    end

    assign unused_sum = ^{sum[2][SW-1], sum[2][6:0], sum[1][SW-1], sum[1][6:0],
                          sum[0][SW-1], sum[0][6:0]};

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            primed_q <= 1'b0;
            p0_q     <= '0;
            p1_q     <= '0;
            prod0_q  <= '0;
            prod1_q  <= '0;
            s1_vld_q <= 1'b0;
            out_q    <= '0;
            dval_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            primed_q <= primed_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            prod0_q  <= prod0_d;
            prod1_q  <= prod1_d;
            s1_vld_q <= s1_vld_d;
            out_q    <= out_d;
            dval_q   <= dval_d;
            cnt_q    <= cnt_d;
        end
    end

    assign oDVAL    = dval_q;
    assign oR       = out_q[2];
    assign oG       = out_q[1];
    assign oB       = out_q[0];
    // Stage-1 valid is iEN one cycle ahead of oDVAL; its absence marks the last pixel.
    assign oEOL     = dval_q & ~s1_vld_q;
    assign oPIX_CNT = cnt_q;

endmodule

// File: tb/tb_scaler_interp_hor.sv
// Scoreboard bench for scaler_interp_hor: directed stimulus pushes hand-computed pixels,
// a negedge monitor pops and compares whenever oDVAL is high.
module tb_scaler_interp_hor;

    logic        iCLK;
    logic        iRSTN;
    logic        iEN;
    logic [6:0]  iWEIGHT;
    logic        iPIX_EN;
    logic [7:0]  iR, iG, iB;
    logic        oDVAL;
    logic [7:0]  oR, oG, oB;
    logic        oEOL;
    logic [10:0] oPIX_CNT;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [10:0] cnt;
        logic        eol;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    scaler_interp_hor #(.DW(8), .CW(11)) dut (
        .iCLK     (iCLK),
        .iRSTN    (iRSTN),
        .iEN      (iEN),
        .iWEIGHT  (iWEIGHT),
        .iPIX_EN  (iPIX_EN),
        .iR       (iR),
        .iG       (iG),
        .iB       (iB),
        .oDVAL    (oDVAL),
        .oR       (oR),
        .oG       (oG),
        .oB       (oB),
        .oEOL     (oEOL),
        .oPIX_CNT (oPIX_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic en, input logic [6:0] w, input logic pe,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        iEN = en; iWEIGHT = w; iPIX_EN = pe; iR = r; iG = g; iB = b;
        @(posedge iCLK);
        #1;
    endtask

    task automatic expect_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [10:0] cnt, input logic eol);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.cnt = cnt; e.eol = eol;
        exp_q.push_back(e);
    endtask

    always @(negedge iCLK) begin
        if (iRSTN && oDVAL) begin
            exp_t e;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got rgb=%0d/%0d/%0d cnt=%0d eol=%0d, expected none",
                         oR, oG, oB, oPIX_CNT, oEOL);
            end else begin
                e = exp_q.pop_front();
                if (oR !== e.r || oG !== e.g || oB !== e.b || oPIX_CNT !== e.cnt ||
                    oEOL !== e.eol) begin
                    n_fail++;
                    $display("FAIL pixel: got rgb=%0d/%0d/%0d cnt=%0d eol=%0d, expected rgb=%0d/%0d/%0d cnt=%0d eol=%0d",
                             oR, oG, oB, oPIX_CNT, oEOL, e.r, e.g, e.b, e.cnt, e.eol);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs
        iRSTN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom));
            check("rst_dval", int'(oDVAL), 0);
            check("rst_eol", int'(oEOL), 0);
            check("rst_rgb", int'({oR, oG, oB}), 0);
            check("rst_cnt", int'(oPIX_CNT), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        iRSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check("idle_dval", int'(oDVAL), 0);
        end

        // Prime and hold: one strobe, then 4 outputs at w=64
        drive(0, 0, 1, 200, 100, 50);
        for (int i = 0; i < 4; i++) begin
            expect_px(200, 100, 50, 11'(i), i == 3);
            drive(1, 64, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0);

        // Blend and rounding: p0=(10,30,0) p1=(20,40,0)
        drive(0, 0, 1, 10, 30, 0);
        drive(0, 0, 1, 20, 40, 0);
        expect_px(15, 35, 0, 0, 0);  drive(1, 64, 0, 0, 0, 0);
        expect_px(20, 40, 0, 1, 0);  drive(1, 127, 0, 0, 0, 0);
        expect_px(10, 30, 0, 2, 1);  drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Extremes: p0=(0,255,255) p1=(255,255,0)
        drive(0, 0, 1, 0, 255, 255);
        drive(0, 0, 1, 255, 255, 0);
        expect_px(253, 255, 2, 0, 0);  drive(1, 127, 0, 0, 0, 0);
        expect_px(2, 255, 253, 1, 1);  drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // Back-to-back single-cycle line: counter restarts, window held
        expect_px(0, 255, 255, 0, 1);  drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Same-cycle strobe uses old taps; next blend sees shifted window
        drive(0, 0, 1, 50, 60, 0);
        expect_px(50, 60, 0, 0, 0);  drive(1, 127, 1, 90, 10, 0);
        expect_px(90, 10, 0, 1, 1);  drive(1, 127, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Mid-line reset
        drive(0, 0, 1, 10, 10, 10);
        expect_px(10, 10, 10, 0, 0);  drive(1, 0, 1, 20, 20, 20);
        expect_px(10, 10, 10, 1, 0);  drive(1, 0, 1, 30, 30, 30);
        expect_px(20, 20, 20, 2, 0);  drive(1, 0, 1, 40, 40, 40);
        expect_px(30, 30, 30, 3, 0);  drive(1, 0, 1, 50, 50, 50);
        iRSTN = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_dval", int'(oDVAL), 0);
        check("midrst_cnt", int'(oPIX_CNT), 0);
        check("midrst_eol", int'(oEOL), 0);
        drive(1, 0, 1, 99, 99, 99);
        iRSTN = 1'b1;
        expect_px(0, 0, 0, 0, 0);     drive(1, 0, 1, 60, 60, 60);
        check("postrst_dval", int'(oDVAL), 0);
        expect_px(60, 60, 60, 1, 0);  drive(1, 0, 1, 70, 70, 70);
        expect_px(70, 70, 70, 2, 0);  drive(1, 127, 0, 0, 0, 0);
        expect_px(65, 65, 65, 3, 1);  drive(1, 64, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
